// File: rtl/mac_unit_bitserial_seq.sv
// mac_unit_bitserial_seq
//
// Self-sequencing bit-serial multiply-accumulate unit. One job consists of a
// signed activation vector, a mode pair (accumulate / max-pool) and a previous
// result, followed by WEIGHT_BITS weight bit-columns delivered LSB-first. Each
// column is reduced to a masked activation sum, shifted by its bit position
// and accumulated; the MSB column carries negative weight (two's complement).
// The final accumulator is scaled, saturated and optionally max-pooled
// against the previous result.
//
// Ports:
//   clk            clock, single domain
//   reset          synchronous active-high reset
//   start_i        job request, accepted when start_i & start_ready_o
//   start_ready_o  high only while idle
//   act_i          VEC_LENGTH packed signed activations, element i at
//                  act_i[i*DATA_WIDTH +: DATA_WIDTH], latched on accept
//   accum_en_i     1 = accumulator starts from result_prev_i, 0 = from zero
//   pool_en_i      1 = result is max(computed, result_prev), latched on accept
//   result_prev_i  signed previous result, latched on accept
//   w_col_i        weight bit-column, bit i belongs to weight i
//   col_valid_i    w_col_i valid
//   col_ready_o    high only while consuming columns
//   result_o       signed result, valid when out_valid_o
//   out_valid_o    result valid, held until out_ready_i
//   out_ready_i    downstream accept

module mac_unit_bitserial_seq #(
  parameter int DATA_WIDTH   = 8,
  parameter int VEC_LENGTH   = 16,
  parameter int WEIGHT_BITS  = 8,
  parameter int ACC_WIDTH    = 24,
  parameter int RESULT_WIDTH = 16,
  parameter int OUT_SHIFT    = 0
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start_i,
  output logic                             start_ready_o,
  input  logic [DATA_WIDTH*VEC_LENGTH-1:0] act_i,
  input  logic                             accum_en_i,
  input  logic                             pool_en_i,
  input  logic [RESULT_WIDTH-1:0]          result_prev_i,
  input  logic [VEC_LENGTH-1:0]            w_col_i,
  input  logic                             col_valid_i,
  output logic                             col_ready_o,
  output logic [RESULT_WIDTH-1:0]          result_o,
  output logic                             out_valid_o,
  input  logic                             out_ready_i
);

  localparam int PSUM_WIDTH = DATA_WIDTH + $clog2(VEC_LENGTH);
  localparam int TERM_WIDTH = PSUM_WIDTH + WEIGHT_BITS - 1;
  localparam int CNT_WIDTH  = $clog2(WEIGHT_BITS);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_OUT   = 2'd3;

  logic [1:0]                      state_q, state_d;
  logic [DATA_WIDTH*VEC_LENGTH-1:0] act_q, act_d;
  logic                            poolEn_q, poolEn_d;
  logic signed [RESULT_WIDTH-1:0]  resultPrev_q, resultPrev_d;
  logic [CNT_WIDTH-1:0]            colCnt_q, colCnt_d;
  logic                            s1Valid_q, s1Valid_d;
  logic signed [ACC_WIDTH-1:0]     term_q, term_d;
  logic signed [ACC_WIDTH-1:0]     acc_q, acc_d;

  logic                            accept;
  logic                            transfer;
  logic                            lastCol;
  logic signed [PSUM_WIDTH-1:0]    psum;
  logic signed [TERM_WIDTH-1:0]    shifted;
  logic signed [ACC_WIDTH-1:0]     termExt;
  logic signed [ACC_WIDTH-1:0]     accInit;
  logic signed [ACC_WIDTH-1:0]     accShifted;
  logic [ACC_WIDTH-RESULT_WIDTH:0] accUpper;
  logic signed [RESULT_WIDTH-1:0]  computed;

  assign accept   = (state_q == ST_IDLE) && start_i;
  assign transfer = (state_q == ST_RUN) && col_valid_i;
  assign lastCol  = (colCnt_q == CNT_WIDTH'(WEIGHT_BITS - 1));

  assign start_ready_o = (state_q == ST_IDLE);
  assign col_ready_o   = (state_q == ST_RUN);
  assign out_valid_o   = (state_q == ST_OUT);

  // Column reduction: sum the latched activations whose weight bit is set in
  // the current column. The sum is wide enough that it can never overflow.
  always_comb begin
    psum = '0;
    for (int i = 0; i < VEC_LENGTH; i++) begin
      if (w_col_i[i]) begin
        psum = psum + PSUM_WIDTH'($signed(act_q[i*DATA_WIDTH +: DATA_WIDTH]));
      end
    end
  end

  // Weight the column sum by its bit position. The MSB column is the sign bit
  // of a two's-complement weight, so its contribution is subtracted; the
  // negation happens at accumulator width so the most negative column sum
  // cannot wrap.
  assign shifted = TERM_WIDTH'(psum) <<< colCnt_q;
  assign termExt = ACC_WIDTH'(shifted);
  assign accInit = ACC_WIDTH'($signed(result_prev_i)) <<< OUT_SHIFT;

  // Output scaling and saturation: the value fits the result width exactly
  // when every accumulator bit from the result sign bit upward agrees.
  assign accShifted = acc_q >>> OUT_SHIFT;
  assign accUpper   = accShifted[ACC_WIDTH-1:RESULT_WIDTH-1];

  always_comb begin
    if ((&accUpper) || !(|accUpper)) begin
      computed = accShifted[RESULT_WIDTH-1:0];
    end else if (accShifted[ACC_WIDTH-1]) begin
      computed = {1'b1, {(RESULT_WIDTH-1){1'b0}}};
    end else begin
      computed = {1'b0, {(RESULT_WIDTH-1){1'b1}}};
    end
  end

  // Optional max-pooling against the previous result (signed compare).
  assign result_o = (poolEn_q && (resultPrev_q > computed)) ? resultPrev_q : computed;

  // Job sequencing: accept a job, consume WEIGHT_BITS columns, spend one
  // cycle letting the final term reach the accumulator, then present the
  // result until the downstream side takes it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept) state_d = ST_RUN;
      ST_RUN:   if (transfer && lastCol) state_d = ST_DRAIN;
      ST_DRAIN: state_d = ST_OUT;
      ST_OUT:   if (out_ready_i) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Datapath next-state: job inputs latch on accept, stage 1 registers one
  // weighted term per column transfer, stage 2 folds the registered term into
  // the accumulator one cycle later. Accept and a pending term never overlap
  // because stage 1 is always empty by the time the unit is idle.
  always_comb begin
    act_d        = act_q;
    poolEn_d     = poolEn_q;
    resultPrev_d = resultPrev_q;
    colCnt_d     = colCnt_q;
    s1Valid_d    = transfer;
    term_d       = term_q;
    acc_d        = acc_q;
    if (accept) begin
      act_d        = act_i;
      poolEn_d     = pool_en_i;
      resultPrev_d = result_prev_i;
      colCnt_d     = '0;
      acc_d        = accum_en_i ? accInit : '0;
    end else if (s1Valid_q) begin
      acc_d = acc_q + term_q;
    end
    if (transfer) begin
      term_d   = lastCol ? -termExt : termExt;
      colCnt_d = lastCol ? '0 : colCnt_q + CNT_WIDTH'(1);
    end
  end

  // State registers with synchronous reset; reset abandons any job in flight
  // and clears every latched input so nothing leaks into the next job.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      act_q        <= '0;
      poolEn_q     <= 1'b0;
      resultPrev_q <= '0;
      colCnt_q     <= '0;
      s1Valid_q    <= 1'b0;
      term_q       <= '0;
      acc_q        <= '0;
    end else begin
      state_q      <= state_d;
      act_q        <= act_d;
      poolEn_q     <= poolEn_d;
      resultPrev_q <= resultPrev_d;
      colCnt_q     <= colCnt_d;
      s1Valid_q    <= s1Valid_d;
      term_q       <= term_d;
      acc_q        <= acc_d;
    end
  end

endmodule

// File: tb/tb_mac_unit_bitserial_seq.sv
// tb_mac_unit_bitserial_seq
//
// Directed testbench for mac_unit_bitserial_seq with default parameters.
// Each job drives a uniform or hand-picked activation/weight set, feeds the
// weight bit-columns LSB-first and compares the result against hand-computed
// values, along with handshake timing, hold behaviour and reset abort.

module tb_mac_unit_bitserial_seq;

  localparam int DW = 8;
  localparam int VL = 16;
  localparam int WB = 8;
  localparam int RW = 16;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 start;
  logic                 start_ready;
  logic [DW*VL-1:0]     act;
  logic                 accum_en;
  logic                 pool_en;
  logic [RW-1:0]        result_prev;
  logic [VL-1:0]        w_col;
  logic                 col_valid;
  logic                 col_ready;
  logic signed [RW-1:0] result;
  logic                 out_valid;
  logic                 out_ready;

  int cyc = 0;
  int assertCount = 0;
  int failCount = 0;
  int actV[VL];
  int wV[VL];

  mac_unit_bitserial_seq #(
    .DATA_WIDTH(DW), .VEC_LENGTH(VL), .WEIGHT_BITS(WB),
    .ACC_WIDTH(24), .RESULT_WIDTH(RW), .OUT_SHIFT(0)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start_i(start),
    .start_ready_o(start_ready),
    .act_i(act),
    .accum_en_i(accum_en),
    .pool_en_i(pool_en),
    .result_prev_i(result_prev),
    .w_col_i(w_col),
    .col_valid_i(col_valid),
    .col_ready_o(col_ready),
    .result_o(result),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready)
  );

  // Free-running clock and a cycle counter used for latency checks.
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Hard time limit so a stuck design still ends the run.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: time limit reached, failures so far %0d", failCount);
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic signed [31:0] observed,
                             input logic signed [31:0] expected);
    assertCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic setUniform(input int a, input int w);
    for (int i = 0; i < VL; i++) begin
      actV[i] = a;
      wV[i]   = w;
    end
  endtask

  // Runs one job from accept to handshake. Optional random column gaps,
  // start held high during RUN, and a number of cycles with out_ready low
  // (during which col_valid is also driven to show it is ignored).
  task automatic applyStimulus(input string tag, input int accumEn, input int poolEn,
                               input int prev, input int expected, input bit gaps,
                               input int holdCycles, input bit startInRun);
    int acceptCyc;
    int g;
    checkOutput({tag, " start_ready idle"}, start_ready, 1);
    for (int i = 0; i < VL; i++) act[i*DW +: DW] = actV[i][DW-1:0];
    accum_en    = accumEn[0];
    pool_en     = poolEn[0];
    result_prev = prev[RW-1:0];
    start       = 1'b1;
    acceptCyc   = cyc;
    tick();
    start       = 1'b0;
    act         = {$urandom, $urandom, $urandom, $urandom};
    result_prev = 16'h5a5a;
    accum_en    = ~accum_en;
    pool_en     = ~pool_en;
    for (int c = 0; c < WB; c++) begin
      g = gaps ? $urandom_range(0, 2) : 0;
      for (int k = 0; k < g; k++) begin
        col_valid = 1'b0;
        w_col     = 16'($urandom);
        start     = startInRun;
        tick();
      end
      if (startInRun) checkOutput({tag, " start_ready in RUN"}, start_ready, 0);
      col_valid = 1'b1;
      start     = startInRun;
      for (int i = 0; i < VL; i++) w_col[i] = wV[i][c];
      tick();
    end
    col_valid = 1'b0;
    start     = 1'b0;
    checkOutput({tag, " out_valid in DRAIN"}, out_valid, 0);
    tick();
    checkOutput({tag, " out_valid rise"}, out_valid, 1);
    if (!gaps) checkOutput({tag, " latency"}, cyc - acceptCyc, WB + 2);
    checkOutput({tag, " result"}, result, expected);
    for (int h = 0; h < holdCycles; h++) begin
      col_valid = 1'b1;
      w_col     = '1;
      tick();
      checkOutput({tag, " out_valid held"}, out_valid, 1);
      checkOutput({tag, " result held"}, result, expected);
    end
    col_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checkOutput({tag, " out_valid after handshake"}, out_valid, 0);
    checkOutput({tag, " start_ready after handshake"}, start_ready, 1);
  endtask

  initial begin
    int sawValid;
    reset       = 1'b1;
    start       = 1'b0;
    act         = '0;
    accum_en    = 1'b0;
    pool_en     = 1'b0;
    result_prev = '0;
    w_col       = '0;
    col_valid   = 1'b0;
    out_ready   = 1'b0;
    repeat (3) tick();
    reset = 1'b0;

    checkOutput("reset start_ready", start_ready, 1);
    checkOutput("reset col_ready", col_ready, 0);
    checkOutput("reset out_valid", out_valid, 0);
    checkOutput("reset result", result, 0);
    tick();

    // 16 x (1 * 1)
    setUniform(1, 1);
    applyStimulus("sum_of_weights", 0, 0, 0, 16, 1'b0, 0, 1'b0);

    // 16 x (3 * -1): MSB column negation
    setUniform(3, -1);
    applyStimulus("msb_negation", 0, 0, 0, -48, 1'b0, 0, 1'b0);
    applyStimulus("pool_prev_wins", 0, 1, 100, 100, 1'b0, 0, 1'b0);
    applyStimulus("pool_computed_wins", 0, 1, -200, -48, 1'b0, 0, 1'b0);

    // 30000 + 16*127*127 = 288064 -> saturates high
    setUniform(127, 127);
    applyStimulus("accum_sat_pos", 1, 0, 30000, 32767, 1'b0, 0, 1'b0);

    // -32768 + 16*127*(-128) = -292864 -> saturates low
    setUniform(127, -128);
    applyStimulus("accum_sat_neg", 1, 0, -32768, -32768, 1'b0, 0, 1'b0);

    // -100 + 16 = -84, accumulate without saturation
    setUniform(1, 1);
    applyStimulus("accum_plain", 1, 0, -100, -84, 1'b0, 0, 1'b0);

    // act[i] = i-7, w even = 2, w odd = -3: 2*0 + (-3)*8 = -24
    for (int i = 0; i < VL; i++) begin
      actV[i] = i - 7;
      wV[i]   = (i % 2 == 0) ? 2 : -3;
    end
    applyStimulus("mixed_vector", 0, 0, 0, -24, 1'b0, 0, 1'b0);

    // Random column gaps, start held during RUN, out_ready low for 5 cycles
    setUniform(3, -1);
    applyStimulus("handshake_stress", 0, 0, 0, -48, 1'b1, 5, 1'b1);

    // Abort a job after three columns
    setUniform(7, 9);
    for (int i = 0; i < VL; i++) act[i*DW +: DW] = actV[i][DW-1:0];
    accum_en    = 1'b1;
    pool_en     = 1'b1;
    result_prev = 16'd1000;
    start       = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 3; c++) begin
      col_valid = 1'b1;
      for (int i = 0; i < VL; i++) w_col[i] = wV[i][c];
      tick();
    end
    col_valid = 1'b0;
    reset     = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("abort start_ready", start_ready, 1);
    checkOutput("abort col_ready", col_ready, 0);
    checkOutput("abort out_valid", out_valid, 0);
    checkOutput("abort result", result, 0);
    sawValid = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (out_valid !== 1'b0) sawValid++;
    end
    checkOutput("abort no out_valid", sawValid, 0);

    // Fresh job after abort: 16 x (2 * 5) = 160
    setUniform(2, 5);
    applyStimulus("after_abort", 0, 0, 0, 160, 1'b0, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
